load_store_memory: RTL and testbench

LOAD_STORE_MEMORY -- requirements
Module: load_store_memory

---
 rtl/load_store_memory.sv | 144 ++++++++++++++
 tb/tb_load_store_memory.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_memory.sv
// Byte-addressable RV32I data memory: lb/lh/lw/lbu/lhu loads, sb/sh/sw stores.
// Define DMEM_INIT_CLEAR_EN to zero all words after reset, one word per cycle.
module load_store_memory #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           writeData,
    input  logic                  memWrite,
    input  logic                  memRead,
    input  logic [2:0]            funct3,
    output logic [31:0]           ReadData,
    output logic                  readValid,
    output logic                  busy,
    output logic                  misaligned,
    output logic                  outOfRange
);

    localparam int IDXW = $clog2(DEPTH_WORDS);

    logic [31:0]           r_mem [DEPTH_WORDS];
    logic [IDXW-1:0]       w_idx;
    logic [ADDR_WIDTH-1:0] w_hi;
    logic [1:0]            w_size;
    logic                  w_ok;
    logic                  w_mis;
    logic                  w_oor;
    logic                  w_req;
    logic                  w_go;
    logic                  w_st;
    logic                  w_ld;
    logic [31:0]           w_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_ld_data;
    logic                  w_clr;
    logic [IDXW-1:0]       w_clr_idx;

    assign w_idx  = address[IDXW+1:2];
    assign w_hi   = address >> (IDXW + 2);
    assign w_oor  = |w_hi;
    assign w_size = funct3[1:0];

    // Stores only know 000/001/010; loads add the unsigned 100/101
    always_comb begin
        w_ok = 1'b0;
        if (memWrite)
            w_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else
            w_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010)
                || (funct3 == 3'b100) || (funct3 == 3'b101);
    end

    assign w_mis = ((w_size == 2'b01) && address[0])
                || ((w_size == 2'b10) && (address[1:0] != 2'b00));
    assign w_req = (memWrite || memRead) && !busy && !reset && w_ok;
    assign w_go  = w_req && !w_mis && !w_oor;
    assign w_st  = w_go && memWrite;
    assign w_ld  = w_go && memRead && !memWrite;

    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{address[1:0], 3'b000} +: 8];
    assign w_half = address[1] ? w_word[31:16] : w_word[15:0];

    // Extend the selected lane(s) according to the access type
    always_comb begin
        w_ld_data = w_word;
        case (funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_data = {24'h0, w_byte};
            3'b101:  w_ld_data = {16'h0, w_half};
            default: w_ld_data = w_word;
        endcase
    end

`ifdef DMEM_INIT_CLEAR_EN
    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t          r_state;
    logic [IDXW-1:0] r_clr_idx;
    logic            r_busy;

    // Clear sequencer: walks every word after reset, then parks in IDLE
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == IDXW'(DEPTH_WORDS - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign busy      = r_busy;
    assign w_clr     = (r_state == S_CLEAR) && !reset;
    assign w_clr_idx = r_clr_idx;
`else
    assign busy      = 1'b0;
    assign w_clr     = 1'b0;
    assign w_clr_idx = '0;
`endif

    // Storage: clear walk has the port while busy, otherwise lane-masked stores
    always_ff @(posedge clock) begin
        if (w_clr) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_st) begin
            case (w_size)
                2'b00:   r_mem[w_idx][{address[1:0], 3'b000} +: 8] <= writeData[7:0];
                2'b01:   r_mem[w_idx][{address[1], 4'b0000} +: 16] <= writeData[15:0];
                default: r_mem[w_idx] <= writeData;
            endcase
        end
    end

    // Registered load result and one-cycle fault pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            ReadData   <= '0;
            readValid  <= 1'b0;
            misaligned <= 1'b0;
            outOfRange <= 1'b0;
        end else begin
            readValid  <= w_ld;
            misaligned <= w_req && w_mis;
            outOfRange <= w_req && !w_mis && w_oor;
            if (w_ld)
                ReadData <= w_ld_data;
        end
    end

endmodule

// File: tb/tb_load_store_memory.sv
// Directed bench for load_store_memory; clear-on-reset checks run only
// when DMEM_INIT_CLEAR_EN is defined for the build.
module tb_load_store_memory;

    logic        clock;
    logic        reset;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        memWrite;
    logic        memRead;
    logic [2:0]  funct3;
    logic [31:0] ReadData;
    logic        readValid;
    logic        busy;
    logic        misaligned;
    logic        outOfRange;

    int n_checks = 0;
    int n_errors = 0;

    load_store_memory #(.DEPTH_WORDS(64), .ADDR_WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .writeData  (writeData),
        .memWrite   (memWrite),
        .memRead    (memRead),
        .funct3     (funct3),
        .ReadData   (ReadData),
        .readValid  (readValid),
        .busy       (busy),
        .misaligned (misaligned),
        .outOfRange (outOfRange)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one request for one edge; returns #1 after that edge
    task automatic req(input logic we, input logic re, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
        memWrite  = we;
        memRead   = re;
        funct3    = f3;
        address   = a;
        writeData = wd;
        @(posedge clock);
        #1;
        memWrite = 1'b0;
        memRead  = 1'b0;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        req(1'b1, 1'b0, f3, a, wd);
    endtask

    task automatic load(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] exp);
        req(1'b0, 1'b1, f3, a, 32'h0);
        check({tag, ".rv"}, {31'h0, readValid}, 32'h1);
        check({tag, ".data"}, ReadData, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Count cycles with busy high, bounded so a stuck busy cannot hang
    task automatic busy_count(input string tag, input int exp);
        int cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            step();
        end
        check(tag, cnt, exp);
    endtask

    initial begin
        reset     = 1'b0;
        address   = '0;
        writeData = '0;
        memWrite  = 1'b0;
        memRead   = 1'b0;
        funct3    = 3'b000;

        do_reset();
        check("rst.rv", {31'h0, readValid}, 32'h0);
        check("rst.mis", {31'h0, misaligned}, 32'h0);
        check("rst.oor", {31'h0, outOfRange}, 32'h0);
        check("rst.data", ReadData, 32'h0);

`ifdef DMEM_INIT_CLEAR_EN
        busy_count("clr.busy", 64);
        for (int i = 0; i < 64; i++)
            load($sformatf("clr.lw%0d", i), 3'b010, 32'(i * 4), 32'h0);
`else
        check("busy0", {31'h0, busy}, 32'h0);
`endif

        store(3'b010, 32'h10, 32'h80F0A1B2);
        load("lb11", 3'b000, 32'h11, 32'hFFFFFFA1);
        load("lbu11", 3'b100, 32'h11, 32'h000000A1);
        load("lh12", 3'b001, 32'h12, 32'hFFFF80F0);
        load("lhu10", 3'b101, 32'h10, 32'h0000A1B2);
        load("lbu13", 3'b100, 32'h13, 32'h00000080);

        store(3'b010, 32'h20, 32'h11223344);
        store(3'b000, 32'h22, 32'h000000EE);
        load("rmw", 3'b010, 32'h20, 32'h11EE3344);
        step();
        check("rmw.pulse", {31'h0, readValid}, 32'h0);
        check("rmw.hold", ReadData, 32'h11EE3344);

        store(3'b010, 32'h24, 32'h00000000);
        store(3'b001, 32'h26, 32'h1234BEEF);
        load("sh26", 3'b010, 32'h24, 32'hBEEF0000);

        store(3'b010, 32'h00, 32'hA5A5A5A5);
        req(1'b0, 1'b1, 3'b010, 32'h06, 32'h0);
        check("lw06.mis", {31'h0, misaligned}, 32'h1);
        check("lw06.rv", {31'h0, readValid}, 32'h0);
        check("lw06.hold", ReadData, 32'hBEEF0000);
        step();
        check("lw06.pulse", {31'h0, misaligned}, 32'h0);
        store(3'b001, 32'h03, 32'h00001111);
        check("sh03.mis", {31'h0, misaligned}, 32'h1);
        load("sh03.mem", 3'b010, 32'h00, 32'hA5A5A5A5);

        req(1'b0, 1'b1, 3'b010, 32'h100, 32'h0);
        check("oor.flag", {31'h0, outOfRange}, 32'h1);
        check("oor.rv", {31'h0, readValid}, 32'h0);
        req(1'b0, 1'b1, 3'b010, 32'h102, 32'h0);
        check("prio.mis", {31'h0, misaligned}, 32'h1);
        check("prio.oor", {31'h0, outOfRange}, 32'h0);
        req(1'b0, 1'b1, 3'b011, 32'h10, 32'h0);
        check("f3.flags", {30'h0, misaligned, outOfRange}, 32'h0);
        check("f3.rv", {31'h0, readValid}, 32'h0);
        store(3'b110, 32'h10, 32'h0);
        load("f3.st", 3'b010, 32'h10, 32'h80F0A1B2);

        req(1'b1, 1'b1, 3'b010, 32'h08, 32'hDEADBEEF);
        check("both.rv", {31'h0, readValid}, 32'h0);
        load("both.lw", 3'b010, 32'h08, 32'hDEADBEEF);

        do_reset();
        check("rst2.data", ReadData, 32'h0);
`ifdef DMEM_INIT_CLEAR_EN
        for (int i = 0; i < 10; i++)
            step();
        do_reset();
        store(3'b010, 32'h30, 32'h12345678);
        busy_count("reclr.busy", 63);
        load("reclr.lw30", 3'b010, 32'h30, 32'h0);
        load("reclr.lw20", 3'b010, 32'h20, 32'h0);
`else
        load("keep.lw20", 3'b010, 32'h20, 32'h11EE3344);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
